ysyx_rnu_sched: RTL and testbench

Rename/dispatch scheduler between the decode stage and the reservation stations. It accepts one decoded instruction per cycle and assigns it a ROB destination tag from a circular allocator. It looks up source dependencies (`qj`/`qk`) in a register-status table and presents the result through a one-entry registered output stage. It frees tags on in-order ROB commit and clears all state on a pipeline flush.

---
 rtl/ysyx_rnu_pkg.sv | 37 +++
 rtl/ysyx_rnu_rat.sv | 73 +++++++
 rtl/ysyx_rnu_sched.sv | 137 +++++++++++++
 tb/tb_ysyx_rnu_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_rnu_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_rnu_pkg
// Shared types and helpers for the rename/dispatch scheduler.
//   rob_tag_t  : ROB destination tag, one bit wider than the ROB index so that
//                value 0 can mean "no producer / operand ready".
//   TAG_NONE   : the "ready" tag value.
//   idx2tag    : ROB index -> tag (index k is tag k+1).
//   tag2idx    : tag -> ROB index (inverse of idx2tag).
// The build-wide sizes normally come from ysyx.svh; the guarded defaults below
// keep this slice self-contained when that header is not on the include path.
// -----------------------------------------------------------------------------
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 8
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

package ysyx_rnu_pkg;

    localparam int ROB_SIZE_DEF = `YSYX_ROB_SIZE;
    localparam int RLEN_DEF     = `YSYX_REG_LEN;
    localparam int TW_DEF       = $clog2(ROB_SIZE_DEF) + 1;

    typedef logic [TW_DEF-1:0] rob_tag_t;

    localparam rob_tag_t TAG_NONE = '0;

    function automatic int idx2tag(input int idx);
        return idx + 1;
    endfunction

    function automatic int tag2idx(input int tag);
        return tag - 1;
    endfunction

endpackage

// File: rtl/ysyx_rnu_rat.sv
// -----------------------------------------------------------------------------
// ysyx_rnu_rat
// Register-status table: for each architectural register, the tag of the
// youngest in-flight producer (0 when the register value is ready).
//   clock, reset        : clock, asynchronous active-low reset
//   flush               : clear every entry on the next edge
//   rd_addr1/2, rd_tag1/2 : two combinational read ports; reads see the
//                         same-cycle commit clear (bypass), x0 always reads 0
//   set_en/addr/tag     : allocate a new producer for a register
//   clr_en/addr/tag     : commit clear, applied only if the entry still holds
//                         the committing tag (a younger writer keeps ownership)
// -----------------------------------------------------------------------------
module ysyx_rnu_rat
    import ysyx_rnu_pkg::*;
#(
    parameter int RLEN = 5,
    parameter int TW   = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic [RLEN-1:0] rd_addr1,
    input  logic [RLEN-1:0] rd_addr2,
    output logic [TW-1:0]   rd_tag1,
    output logic [TW-1:0]   rd_tag2,
    input  logic            set_en,
    input  logic [RLEN-1:0] set_addr,
    input  logic [TW-1:0]   set_tag,
    input  logic            clr_en,
    input  logic [RLEN-1:0] clr_addr,
    input  logic [TW-1:0]   clr_tag
);

    localparam int NREG = 1 << RLEN;

    logic [TW-1:0] st [NREG];
    logic          clr_hit;

    assign clr_hit = clr_en && (st[clr_addr] == clr_tag);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_tag1 = st[rd_addr1];
        rd_tag2 = st[rd_addr2];
        if (rd_addr1 == '0 || (clr_hit && rd_addr1 == clr_addr)) begin
            rd_tag1 = TW'(TAG_NONE);
        end
        if (rd_addr2 == '0 || (clr_hit && rd_addr2 == clr_addr)) begin
            rd_tag2 = TW'(TAG_NONE);
        end
    end

    // NOTE: this table is a bank of flops, not a RAM, so it is reset: both
    // reset and flush must leave every register marked ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) st[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) st[i] <= '0;
        end else begin
            if (clr_hit) begin
                st[clr_addr] <= '0;
            end
            // NOTE: non-blocking assignments; when both target the same entry
            // the later one (the new producer) is the value that lands.
            if (set_en && set_addr != '0) begin
                st[set_addr] <= set_tag;
            end
        end
    end

endmodule

// File: rtl/ysyx_rnu_sched.sv
// -----------------------------------------------------------------------------
// ysyx_rnu_sched
// Rename/dispatch scheduler between decode and the reservation stations.
// Allocates ROB tags round-robin, resolves qj/qk through the status table and
// presents the result from a one-entry registered output stage.
//   clock, reset               : clock, asynchronous active-low reset
//   in_valid/in_ready          : decode handshake
//   in_rs1/rs2/rd/wen/pc       : decoded instruction
//   out_valid/out_ready        : dispatch handshake
//   out_qj/qk/dest/rd/wen/pc   : renamed instruction (registered)
//   cmt_valid/cmt_dest/cmt_rd  : in-order ROB retirement
//   flush                      : squash all in-flight state
//   full                       : every ROB tag is allocated
// -----------------------------------------------------------------------------
module ysyx_rnu_sched
    import ysyx_rnu_pkg::*;
#(
    parameter int RLEN     = RLEN_DEF,
    parameter int XLEN     = 32,
    parameter int ROB_SIZE = ROB_SIZE_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RLEN-1:0]          in_rs1,
    input  logic [RLEN-1:0]          in_rs2,
    input  logic [RLEN-1:0]          in_rd,
    input  logic                     in_wen,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(ROB_SIZE):0] out_qj,
    output logic [$clog2(ROB_SIZE):0] out_qk,
    output logic [$clog2(ROB_SIZE):0] out_dest,
    output logic [RLEN-1:0]          out_rd,
    output logic                     out_wen,
    output logic [XLEN-1:0]          out_pc,
    input  logic                     cmt_valid,
    input  logic [$clog2(ROB_SIZE):0] cmt_dest,
    input  logic [RLEN-1:0]          cmt_rd,
    input  logic                     flush,
    output logic                     full
);

    localparam int IW = $clog2(ROB_SIZE);
    localparam int TW = IW + 1;

    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [TW-1:0] count;
    logic [TW-1:0] tail_tag;
    logic [TW-1:0] qj;
    logic [TW-1:0] qk;
    logic          accept;
    logic          commit;

    // Ready depends only on registered state plus flush/out_ready, so a
    // commit arriving while full cannot reopen the input in the same cycle.
    assign in_ready = !flush && (count < TW'(ROB_SIZE)) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign commit   = cmt_valid && (count != '0) && !flush;
    assign full     = (count == TW'(ROB_SIZE));
    assign tail_tag = TW'(idx2tag(int'(tail)));

    ysyx_rnu_rat #(
        .RLEN (RLEN),
        .TW   (TW)
    ) u_rat (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .rd_addr1 (in_rs1),
        .rd_addr2 (in_rs2),
        .rd_tag1  (qj),
        .rd_tag2  (qk),
        .set_en   (accept && in_wen),
        .set_addr (in_rd),
        .set_tag  (tail_tag),
        .clr_en   (commit),
        .clr_addr (cmt_rd),
        .clr_tag  (cmt_dest)
    );

    // Allocator: head/tail wrap naturally because ROB_SIZE is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) tail <= tail + 1'b1;
            if (commit) head <= head + 1'b1;
            case ({accept, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // One-entry output stage; contents only change on a new accept, which
    // requires the previous entry to have been taken, so a stalled entry
    // holds steady.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_qj    <= '0;
            out_qk    <= '0;
            out_dest  <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_qj    <= qj;
            out_qk    <= qk;
            out_dest  <= tail_tag;
            out_rd    <= in_rd;
            out_wen   <= in_wen;
            out_pc    <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // The ROB must retire strictly in allocation order.
    cmt_order_a : assert property (@(posedge clock) disable iff (!reset)
        commit |-> (tag2idx(int'(cmt_dest)) == int'(head)));

endmodule

// File: tb/tb_ysyx_rnu_sched.sv
module tb_ysyx_rnu_sched;
    import ysyx_rnu_pkg::*;

    localparam int RLEN = 5;
    localparam int XLEN = 32;
    localparam int ROB  = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid, in_ready;
    logic [RLEN-1:0] in_rs1, in_rs2, in_rd;
    logic            in_wen;
    logic [XLEN-1:0] in_pc;
    logic            out_valid, out_ready;
    rob_tag_t        out_qj, out_qk, out_dest;
    logic [RLEN-1:0] out_rd;
    logic            out_wen;
    logic [XLEN-1:0] out_pc;
    logic            cmt_valid;
    rob_tag_t        cmt_dest;
    logic [RLEN-1:0] cmt_rd;
    logic            flush;
    logic            full;

    int n_checks = 0;
    int n_fail   = 0;
    int pc_ctr   = 32'h1000;

    ysyx_rnu_sched #(.RLEN(RLEN), .XLEN(XLEN), .ROB_SIZE(ROB)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_qj    (out_qj),
        .out_qk    (out_qk),
        .out_dest  (out_dest),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .out_pc    (out_pc),
        .cmt_valid (cmt_valid),
        .cmt_dest  (cmt_dest),
        .cmt_rd    (cmt_rd),
        .flush     (flush),
        .full      (full)
    );

    always #5 clock = ~clock;

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        in_wen    = 1'b0;
        in_pc     = '0;
        out_ready = 1'b1;
        cmt_valid = 1'b0;
        cmt_dest  = '0;
        cmt_rd    = '0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;   // released 1 time unit after an edge
    endtask

    task automatic drive_in(input int rs1, input int rs2, input int rd, input bit wen);
        in_valid = 1'b1;
        in_rs1   = RLEN'(rs1);
        in_rs2   = RLEN'(rs2);
        in_rd    = RLEN'(rd);
        in_wen   = wen;
        in_pc    = XLEN'(pc_ctr);
        pc_ctr   = pc_ctr + 4;
    endtask

    // Offer one instruction for one edge (caller guarantees in_ready).
    task automatic issue(input int rs1, input int rs2, input int rd, input bit wen);
        drive_in(rs1, rs2, rd, wen);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic set_cmt(input bit v, input int dest, input int rd);
        cmt_valid = v;
        cmt_dest  = rob_tag_t'(dest);
        cmt_rd    = RLEN'(rd);
    endtask

    task automatic chk_out(input string n, input int qj, input int qk, input int dest);
        check({n, ".valid"}, 64'(out_valid), 64'(1));
        check({n, ".qj"},    64'(out_qj),    64'(qj));
        check({n, ".qk"},    64'(out_qk),    64'(qk));
        check({n, ".dest"},  64'(out_dest),  64'(dest));
    endtask

    // --------------------------------------------------------- reference model
    typedef struct {
        int tag;
        int rd;
        bit wen;
    } ent_t;

    ent_t q[$];   // allocated, not yet committed, oldest first

    // Producer of a register = youngest in-flight writer of it.
    function automatic int producer(input int r);
        if (r == 0) return 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].wen && q[i].rd == r) return q[i].tag;
        end
        return 0;
    endfunction

    // ------------------------------------------------------------ vector table
    typedef struct {
        int rs1;
        int rs2;
        int rd;
        bit wen;
        int qj;
        int qk;
        int dest;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{rs1: 1, rs2: 2, rd: 5, wen: 1, qj: 0, qk: 0, dest: 1};
        vt[1] = '{rs1: 5, rs2: 0, rd: 6, wen: 1, qj: 1, qk: 0, dest: 2};
        vt[2] = '{rs1: 6, rs2: 5, rd: 0, wen: 1, qj: 2, qk: 1, dest: 3};
        vt[3] = '{rs1: 0, rs2: 0, rd: 7, wen: 0, qj: 0, qk: 0, dest: 4};
        vt[4] = '{rs1: 7, rs2: 0, rd: 5, wen: 1, qj: 0, qk: 0, dest: 5};
        vt[5] = '{rs1: 5, rs2: 6, rd: 1, wen: 0, qj: 5, qk: 2, dest: 6};
        vt[6] = '{rs1: 0, rs2: 5, rd: 0, wen: 1, qj: 0, qk: 5, dest: 7};

        // ---------------------------------------------------------- reset state
        idle_inputs();
        reset = 1'b0;
        tick();
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.full",      64'(full),      64'(0));
        check("rst.out_dest",  64'(out_dest),  64'(0));
        check("rst.out_qj",    64'(out_qj),    64'(0));
        check("rst.out_pc",    64'(out_pc),    64'(0));
        check("rst.in_ready",  64'(in_ready),  64'(1));
        tick();
        reset = 1'b1;

        // ---------------------------------------------------- table-driven run
        for (int i = 0; i < 7; i++) begin
            issue(vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].wen);
            chk_out($sformatf("vec%0d", i), vt[i].qj, vt[i].qk, vt[i].dest);
        end

        // --------------------------------------------------- fill, commit, wrap
        do_reset();
        for (int i = 0; i < ROB; i++) issue(0, 0, i + 1, 1'b1);
        check("fill.full",     64'(full),     64'(1));
        check("fill.in_ready", 64'(in_ready), 64'(0));
        check("fill.dest",     64'(out_dest), 64'(8));
        drive_in(2, 0, 3, 1'b1);
        set_cmt(1'b1, 1, 1);
        #1;
        check("fill.ready_same_cycle_commit", 64'(in_ready), 64'(0));
        tick();
        set_cmt(1'b0, 0, 0);
        check("fill.ready_after_commit", 64'(in_ready), 64'(1));
        check("fill.full_after_commit",  64'(full),     64'(0));
        tick();
        in_valid = 1'b0;
        chk_out("wrap", 2, 0, 1);

        // ------------------------------------- commit bypass / younger owner
        do_reset();
        issue(0, 0, 5, 1'b1);            // tag 1
        issue(0, 0, 5, 1'b1);            // tag 2
        issue(0, 0, 5, 1'b1);            // tag 3, st[x5]=3
        set_cmt(1'b1, 1, 5);
        tick();
        set_cmt(1'b1, 2, 5);             // older writer retires
        issue(5, 0, 9, 1'b1);            // tag 4
        chk_out("younger_owner", 3, 0, 4);
        set_cmt(1'b1, 3, 5);             // owner retires while x5 is read
        issue(5, 0, 0, 1'b0);            // tag 5
        chk_out("cmt_bypass", 0, 0, 5);
        set_cmt(1'b0, 0, 0);
        issue(5, 9, 0, 1'b0);            // tag 6
        chk_out("after_clear", 0, 4, 6);

        // ------------------------------------------ accept write beats clear
        do_reset();
        issue(0, 0, 1, 1'b1);            // tag 1
        issue(0, 0, 7, 1'b1);            // tag 2
        issue(0, 0, 2, 1'b1);            // tag 3
        set_cmt(1'b1, 1, 1);
        tick();
        set_cmt(1'b1, 2, 7);
        issue(0, 0, 7, 1'b1);            // tag 4, same edge as clear of x7
        set_cmt(1'b0, 0, 0);
        issue(7, 0, 0, 1'b0);
        chk_out("write_wins", 4, 0, 5);

        // -------------------------------------------- back-pressure, flush
        do_reset();
        issue(1, 2, 5, 1'b1);            // tag 1
        issue(3, 4, 7, 1'b1);            // tag 2
        begin
            logic [XLEN-1:0] held_pc;
            held_pc   = out_pc;
            out_ready = 1'b0;
            drive_in(5, 7, 9, 1'b1);
            for (int k = 0; k < 3; k++) begin
                #1;
                check($sformatf("stall%0d.in_ready", k), 64'(in_ready), 64'(0));
                tick();
                check($sformatf("stall%0d.valid", k), 64'(out_valid), 64'(1));
                check($sformatf("stall%0d.dest", k),  64'(out_dest),  64'(2));
                check($sformatf("stall%0d.rd", k),    64'(out_rd),    64'(7));
                check($sformatf("stall%0d.pc", k),    64'(out_pc),    64'(held_pc));
                in_pc = in_pc + 4;
            end
        end
        flush = 1'b1;
        #1;
        check("flush.in_ready", 64'(in_ready), 64'(0));
        tick();
        flush = 1'b0;
        check("flush.out_valid", 64'(out_valid), 64'(0));
        check("flush.full",      64'(full),      64'(0));
        out_ready = 1'b1;
        issue(5, 7, 1, 1'b1);
        chk_out("post_flush", 0, 0, 1);

        // -------------------------------------- x0 traffic, async mid reset
        issue(0, 0, 0, 1'b1);            // tag 2 writes x0
        issue(0, 0, 3, 1'b1);            // tag 3 reads x0
        chk_out("x0", 0, 0, 3);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst.out_valid", 64'(out_valid), 64'(0));
        check("async_rst.out_dest",  64'(out_dest),  64'(0));
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("async_rst.in_ready",  64'(in_ready),  64'(1));

        // ------------------------------------------ randomized vs model
        do_reset();
        q.delete();
        begin
            bit              m_valid = 1'b0;
            int              m_tail  = 0;
            int              m_qj = 0, m_qk = 0, m_dest = 0, m_rd = 0;
            bit              m_wen = 1'b0;
            logic [XLEN-1:0] m_pc = '0;
            bit              exp_ready;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                flush     = ($urandom_range(0, 39) == 0);
                in_valid  = ($urandom_range(0, 3) != 0);
                in_rs1    = RLEN'($urandom_range(0, 7));
                in_rs2    = RLEN'($urandom_range(0, 7));
                in_rd     = RLEN'($urandom_range(0, 7));
                in_wen    = 1'($urandom_range(0, 1));
                in_pc     = $urandom();
                out_ready = ($urandom_range(0, 3) != 0);
                if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                    set_cmt(1'b1, q[0].tag, q[0].rd);
                end else begin
                    set_cmt((q.size() == 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                            $urandom_range(0, ROB), $urandom_range(0, 7));
                end
                exp_ready = !flush && (q.size() < ROB) && (!m_valid || out_ready);
                #1;
                check("rnd.in_ready", 64'(in_ready), 64'(exp_ready));

                if (flush) begin
                    q.delete();
                    m_tail  = 0;
                    m_valid = 1'b0;
                end else begin
                    if (cmt_valid && q.size() > 0) void'(q.pop_front());
                    if (in_valid && exp_ready) begin
                        m_qj   = producer(int'(in_rs1));
                        m_qk   = producer(int'(in_rs2));
                        m_dest = m_tail + 1;
                        m_rd   = int'(in_rd);
                        m_wen  = in_wen;
                        m_pc   = in_pc;
                        m_valid = 1'b1;
                        q.push_back('{tag: m_dest, rd: m_rd, wen: m_wen});
                        m_tail = (m_tail + 1) % ROB;
                    end else if (out_ready) begin
                        m_valid = 1'b0;
                    end
                end

                tick();
                check("rnd.out_valid", 64'(out_valid), 64'(m_valid));
                check("rnd.full",      64'(full),      64'(q.size() == ROB));
                if (m_valid) begin
                    check("rnd.qj",   64'(out_qj),   64'(m_qj));
                    check("rnd.qk",   64'(out_qk),   64'(m_qk));
                    check("rnd.dest", 64'(out_dest), 64'(m_dest));
                    check("rnd.rd",   64'(out_rd),   64'(m_rd));
                    check("rnd.wen",  64'(out_wen),  64'(m_wen));
                    check("rnd.pc",   64'(out_pc),   64'(m_pc));
                end
            end
        end

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
